hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core. Drives the hold/flush inputs of the IF/ID register,
//  the PC write enable and the ID/EX bubble. Detects load-use and branch-operand hazards, redirects

---
 rtl/pipe_pkg.sv | 13 +
 rtl/hazard_ctrl_if.sv | 32 +++
 rtl/md_interlock.sv | 56 +++++
 rtl/hazard_ctrl.sv | 65 ++++++
 tb/tb_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the ID-stage pipeline sequencer.
package pipe_pkg;
  typedef enum logic {RUN = 1'b0, MDWAIT = 1'b1} md_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LAT_DEFAULT = 4;

  // $0 is hardwired, so a write to it can never create a dependence.
  function automatic logic reg_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst) && (src != REG_ZERO);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage decode / EX-MEM inputs and pipeline-control outputs of hazard_ctrl.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  import pipe_pkg::*;

  logic [4:0]       id_rs, id_rt;
  logic             id_uses_rs, id_uses_rt;
  logic             id_is_branch, id_br_taken, id_is_jump;
  logic             id_is_muldiv, id_reads_hilo;
  logic             ex_regwrite, ex_memread;
  logic [4:0]       ex_rd;
  logic             mem_memread;
  logic [4:0]       mem_rd;
  logic             pc_write, if_id_hazard, if_flush, id_ex_bubble;
  logic             md_start, md_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_br_taken,
           id_is_jump, id_is_muldiv, id_reads_hilo, ex_regwrite, ex_memread,
           ex_rd, mem_memread, mem_rd,
    input  pc_write, if_id_hazard, if_flush, id_ex_bubble, md_start, md_busy,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_br_taken,
           id_is_jump, id_is_muldiv, id_reads_hilo, ex_regwrite, ex_memread,
           ex_rd, mem_memread, mem_rd,
    output pc_write, if_id_hazard, if_flush, id_ex_bubble, md_start, md_busy,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/md_interlock.sv
// Mult/div busy interlock: issue FSM plus latency down-counter.
module md_interlock
  import pipe_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_is_muldiv,
  input  logic i_reads_hilo,
  input  logic i_hold,
  output logic o_md_start,
  output logic o_md_busy,
  output logic o_md_struct
);
  localparam int            CW   = $clog2(MD_LAT);
  localparam logic [CW-1:0] LOAD = CW'(MD_LAT - 1);

  md_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_md_start  = 1'b0;
    o_md_busy   = 1'b0;
    o_md_struct = 1'b0;
    case (r_state)
      RUN: begin
        if (i_is_muldiv && !i_hold) begin
          o_md_start  = 1'b1;
          w_cnt_nxt   = LOAD;
          w_state_nxt = MDWAIT;
        end
      end
      MDWAIT: begin
        // Only HI/LO consumers and a second mult/div wait; everything else flows.
        o_md_busy   = 1'b1;
        o_md_struct = i_is_muldiv || i_reads_hilo;
        w_cnt_nxt   = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end
endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard detection, fetch redirect and mult/div interlock for the 5-stage core.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hazard_ctrl_if.slave  bus
);
  logic             w_ctl, w_load_use, w_br_ex, w_br_mem, w_haz;
  logic             w_md_start, w_md_struct, w_md_busy;
  logic             w_stall, w_flush;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_comb begin
    w_ctl      = bus.id_is_branch || bus.id_is_jump;
    w_load_use = bus.ex_memread &&
                 (reg_match(bus.id_uses_rs, bus.id_rs, bus.ex_rd) ||
                  reg_match(bus.id_uses_rt, bus.id_rt, bus.ex_rd));
    w_br_ex    = w_ctl && bus.ex_regwrite &&
                 (reg_match(bus.id_uses_rs, bus.id_rs, bus.ex_rd) ||
                  reg_match(bus.id_uses_rt, bus.id_rt, bus.ex_rd));
    w_br_mem   = w_ctl && bus.mem_memread &&
                 (reg_match(bus.id_uses_rs, bus.id_rs, bus.mem_rd) ||
                  reg_match(bus.id_uses_rt, bus.id_rt, bus.mem_rd));
  end

  assign w_haz   = w_load_use || w_br_ex || w_br_mem;
  assign w_stall = w_haz || w_md_struct;
  assign w_flush = !w_stall && (bus.id_is_jump || (bus.id_is_branch && bus.id_br_taken));

  md_interlock #(.MD_LAT(MD_LAT)) u_md (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_is_muldiv  (bus.id_is_muldiv),
    .i_reads_hilo (bus.id_reads_hilo),
    .i_hold       (w_haz),
    .o_md_start   (w_md_start),
    .o_md_busy    (w_md_busy),
    .o_md_struct  (w_md_struct)
  );

  // While reset is held the pipeline must free-run, whatever decode presents.
  assign bus.pc_write     = !i_rst_n || !w_stall;
  assign bus.if_id_hazard = i_rst_n && w_stall;
  assign bus.id_ex_bubble = i_rst_n && w_stall;
  assign bus.if_flush     = i_rst_n && w_flush;
  assign bus.md_start     = i_rst_n && w_md_start;
  assign bus.md_busy      = w_md_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [5:0]  obs;
  logic [15:0] cnt;

  // Output vector order: {pc_write, if_id_hazard, if_flush, id_ex_bubble, md_start, md_busy}
  localparam logic [5:0] O_RUN   = 6'b100000;
  localparam logic [5:0] O_STALL = 6'b010100;
  localparam logic [5:0] O_FLUSH = 6'b101000;
  localparam logic [5:0] O_ISSUE = 6'b100010;
  localparam logic [5:0] O_BUSY  = 6'b100001;
  localparam logic [5:0] O_MDST  = 6'b010101;

  hazard_ctrl_if #(.CNT_W(16)) bus ();

  hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [5:0] outs();
    return {bus.pc_write, bus.if_id_hazard, bus.if_flush, bus.id_ex_bubble,
            bus.md_start, bus.md_busy};
  endfunction

  task automatic clr();
    bus.id_rs = 5'd0;        bus.id_rt = 5'd0;
    bus.id_uses_rs = 1'b0;   bus.id_uses_rt = 1'b0;
    bus.id_is_branch = 1'b0; bus.id_br_taken = 1'b0; bus.id_is_jump = 1'b0;
    bus.id_is_muldiv = 1'b0; bus.id_reads_hilo = 1'b0;
    bus.ex_regwrite = 1'b0;  bus.ex_memread = 1'b0;  bus.ex_rd = 5'd0;
    bus.mem_memread = 1'b0;  bus.mem_rd = 5'd0;
  endtask

  // Move to 1 time unit after the next rising edge and clear decode inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic test_reset();
    clr();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd8; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd8;
    bus.id_is_jump = 1'b1; bus.id_is_muldiv = 1'b1;
    #3;
    obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs, O_RUN); end
    checks++;
    cnt = bus.stall_cnt;
    if (cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", cnt); end
    checks++;
    cnt = bus.flush_cnt;
    if (cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d want 0", cnt); end
    checks++;
    clr();
    #4 rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    cyc();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd8; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd8;
    #2 obs = outs();
    if (obs !== O_STALL) begin errors++; $display("FAIL load_use_stall: got %b want %b", obs, O_STALL); end
    checks++;
    cyc();
    #2 obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL load_use_release: got %b want %b", obs, O_RUN); end
    checks++;
    cnt = bus.stall_cnt;
    if (cnt !== 16'd1) begin errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", cnt); end
    checks++;
  endtask

  task automatic test_no_match();
    cyc();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd0; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd0;
    #2 obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL zero_reg_no_stall: got %b want %b", obs, O_RUN); end
    checks++;
    cyc();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd8; bus.id_uses_rs = 1'b0; bus.id_rs = 5'd8;
    #2 obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL unused_src_no_stall: got %b want %b", obs, O_RUN); end
    checks++;
    cyc();
    bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd9; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd9;
    #2 obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL alu_dep_non_branch: got %b want %b", obs, O_RUN); end
    checks++;
    cnt = bus.stall_cnt;
    if (cnt !== 16'd1) begin errors++; $display("FAIL no_match_stall_cnt: got %0d want 1", cnt); end
    checks++;
  endtask

  task automatic test_branch_ex();
    cyc();
    bus.id_is_branch = 1'b1; bus.id_br_taken = 1'b1; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd9;
    bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd9;
    #2 obs = outs();
    if (obs !== O_STALL) begin errors++; $display("FAIL br_ex_stall: got %b want %b", obs, O_STALL); end
    checks++;
    cyc();
    bus.id_is_branch = 1'b1; bus.id_br_taken = 1'b1; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd9;
    #2 obs = outs();
    if (obs !== O_FLUSH) begin errors++; $display("FAIL br_taken_flush: got %b want %b", obs, O_FLUSH); end
    checks++;
    cyc();
    bus.id_is_branch = 1'b1; bus.id_br_taken = 1'b0;
    #2 obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL br_not_taken: got %b want %b", obs, O_RUN); end
    checks++;
    cnt = bus.flush_cnt;
    if (cnt !== 16'd1) begin errors++; $display("FAIL br_flush_cnt: got %0d want 1", cnt); end
    checks++;
    cnt = bus.stall_cnt;
    if (cnt !== 16'd2) begin errors++; $display("FAIL br_stall_cnt: got %0d want 2", cnt); end
    checks++;
  endtask

  task automatic test_branch_mem();
    cyc();
    bus.id_is_branch = 1'b1; bus.id_uses_rt = 1'b1; bus.id_rt = 5'd10;
    bus.mem_memread = 1'b1; bus.mem_rd = 5'd10;
    #2 obs = outs();
    if (obs !== O_STALL) begin errors++; $display("FAIL br_mem_stall: got %b want %b", obs, O_STALL); end
    checks++;
    cyc();
    bus.id_is_branch = 1'b1; bus.id_uses_rt = 1'b1; bus.id_rt = 5'd10;
    bus.mem_memread = 1'b0; bus.mem_rd = 5'd10;
    #2 obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL br_mem_no_load: got %b want %b", obs, O_RUN); end
    checks++;
    cnt = bus.stall_cnt;
    if (cnt !== 16'd3) begin errors++; $display("FAIL br_mem_stall_cnt: got %0d want 3", cnt); end
    checks++;
  endtask

  task automatic test_jump_priority();
    cyc();
    bus.id_is_jump = 1'b1; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd8;
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd8;
    #2 obs = outs();
    if (obs !== O_STALL) begin errors++; $display("FAIL jump_stall_first: got %b want %b", obs, O_STALL); end
    checks++;
    cyc();
    bus.id_is_jump = 1'b1; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd8;
    #2 obs = outs();
    if (obs !== O_FLUSH) begin errors++; $display("FAIL jump_flush_next: got %b want %b", obs, O_FLUSH); end
    checks++;
    cyc();
    #2;
    cnt = bus.stall_cnt;
    if (cnt !== 16'd4) begin errors++; $display("FAIL jump_stall_cnt: got %0d want 4", cnt); end
    checks++;
    cnt = bus.flush_cnt;
    if (cnt !== 16'd2) begin errors++; $display("FAIL jump_flush_cnt: got %0d want 2", cnt); end
    checks++;
  endtask

  task automatic test_muldiv();
    cyc();
    bus.id_is_muldiv = 1'b1;
    #2 obs = outs();
    if (obs !== O_ISSUE) begin errors++; $display("FAIL mult_issue: got %b want %b", obs, O_ISSUE); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.id_reads_hilo = 1'b1;
      #2 obs = outs();
      if (obs !== O_MDST) begin errors++; $display("FAIL mflo_wait_%0d: got %b want %b", i, obs, O_MDST); end
      checks++;
    end
    cyc();
    bus.id_reads_hilo = 1'b1;
    #2 obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL mflo_release: got %b want %b", obs, O_RUN); end
    checks++;
    cnt = bus.stall_cnt;
    if (cnt !== 16'd7) begin errors++; $display("FAIL mflo_stall_cnt: got %0d want 7", cnt); end
    checks++;
  endtask

  task automatic test_back_to_back();
    // Issue held back by a load-use, then free flow and a second mult/div during MDWAIT
    cyc();
    bus.id_is_muldiv = 1'b1; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd4;
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd4;
    #2 obs = outs();
    if (obs !== O_STALL) begin errors++; $display("FAIL mult_held_by_load: got %b want %b", obs, O_STALL); end
    checks++;
    cyc();
    bus.id_is_muldiv = 1'b1; bus.id_uses_rs = 1'b1; bus.id_rs = 5'd4;
    #2 obs = outs();
    if (obs !== O_ISSUE) begin errors++; $display("FAIL mult_issue_after_hold: got %b want %b", obs, O_ISSUE); end
    checks++;
    cyc();
    bus.id_uses_rs = 1'b1; bus.id_rs = 5'd5;
    #2 obs = outs();
    if (obs !== O_BUSY) begin errors++; $display("FAIL add_flows_in_mdwait: got %b want %b", obs, O_BUSY); end
    checks++;
    cyc();
    bus.id_is_muldiv = 1'b1;
    #2 obs = outs();
    if (obs !== O_MDST) begin errors++; $display("FAIL second_mult_waits: got %b want %b", obs, O_MDST); end
    checks++;
    cyc();
    #2 obs = outs();
    if (obs !== O_BUSY) begin errors++; $display("FAIL last_busy_cycle: got %b want %b", obs, O_BUSY); end
    checks++;
    cyc();
    #2 obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL back_to_idle: got %b want %b", obs, O_RUN); end
    checks++;
    cnt = bus.stall_cnt;
    if (cnt !== 16'd9) begin errors++; $display("FAIL b2b_stall_cnt: got %0d want 9", cnt); end
    checks++;
  endtask

  task automatic test_reset_mdwait();
    cyc();
    bus.id_is_muldiv = 1'b1;
    #2 obs = outs();
    if (obs !== O_ISSUE) begin errors++; $display("FAIL rst_mult_issue: got %b want %b", obs, O_ISSUE); end
    checks++;
    cyc();
    bus.id_reads_hilo = 1'b1;
    #2 obs = outs();
    if (obs !== O_MDST) begin errors++; $display("FAIL rst_mflo_wait: got %b want %b", obs, O_MDST); end
    checks++;
    cyc();
    bus.id_reads_hilo = 1'b1;
    #2 rst_n = 1'b0;
    #1 obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL rst_async_release: got %b want %b", obs, O_RUN); end
    checks++;
    cnt = bus.stall_cnt;
    if (cnt !== 16'd0) begin errors++; $display("FAIL rst_clears_stall_cnt: got %0d want 0", cnt); end
    checks++;
    #1 rst_n = 1'b1;
    cyc();
    bus.id_reads_hilo = 1'b1;
    #2 obs = outs();
    if (obs !== O_RUN) begin errors++; $display("FAIL rst_mflo_free: got %b want %b", obs, O_RUN); end
    checks++;
    cnt = bus.stall_cnt;
    if (cnt !== 16'd0) begin errors++; $display("FAIL rst_post_stall_cnt: got %0d want 0", cnt); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_match();
    test_branch_ex();
    test_branch_mem();
    test_jump_priority();
    test_muldiv();
    test_back_to_back();
    test_reset_mdwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
